// File: rtl/led_pattern_driver.sv
// LED pattern driver: static, blink, flow and PWM-dimmed patterns
// on four active-high LEDs, loaded through a valid/ready command port.
module led_pattern_driver #(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int PWM_DIV     = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_pattern,
  input  logic [3:0] cmd_duty,
  output logic [3:0] led,
  output logic [1:0] cur_mode
);

  localparam int SW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] DIV_LAST  = PW'(PWM_DIV - 1);

  localparam logic [1:0] M_STATIC = 2'd0;
  localparam logic [1:0] M_BLINK  = 2'd1;
  localparam logic [1:0] M_FLOW   = 2'd2;
  localparam logic [1:0] M_PWM    = 2'd3;

  typedef enum logic [1:0] {
    S_OFF,
    S_LOAD,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic          accept;
  logic [1:0]    mode_q;
  logic [3:0]    pat_q;
  logic [3:0]    duty_q;
  logic [SW-1:0] step_cnt, step_nxt;
  logic [PW-1:0] div_cnt, div_nxt;
  logic [3:0]    slot, slot_nxt;
  logic [3:0]    led_nxt;
  logic [1:0]    cur_mode_nxt;
  logic          ready_nxt;
  logic          step_fire;
  logic          div_wrap;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_OFF;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_OFF:   if (accept) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (accept) state_nxt = S_LOAD;
      default: state_nxt = S_OFF;
    endcase
  end

  // On an accept edge the running pattern freezes; LOAD restarts it.
  always_comb begin
    led_nxt      = led;
    cur_mode_nxt = cur_mode;
    step_nxt     = step_cnt;
    div_nxt      = div_cnt;
    slot_nxt     = slot;
    step_fire    = (step_cnt == STEP_LAST);
    div_wrap     = (div_cnt == DIV_LAST);
    ready_nxt    = (state_nxt != S_LOAD);
    unique case (state)
      S_LOAD: begin
        step_nxt     = '0;
        div_nxt      = '0;
        slot_nxt     = '0;
        cur_mode_nxt = mode_q;
        led_nxt      = (mode_q == M_PWM && duty_q == 4'd0) ? 4'b0000 : pat_q;
      end
      S_RUN: begin
        if (!accept) begin
          unique case (mode_q)
            M_STATIC: led_nxt = pat_q;
            M_BLINK: begin
              step_nxt = step_fire ? '0 : step_cnt + SW'(1);
              if (step_fire) led_nxt = (led == 4'b0000) ? pat_q : 4'b0000;
            end
            M_FLOW: begin
              step_nxt = step_fire ? '0 : step_cnt + SW'(1);
              if (step_fire) led_nxt = {led[2:0], led[3]};
            end
            M_PWM: begin
              div_nxt  = div_wrap ? '0 : div_cnt + PW'(1);
              slot_nxt = div_wrap ? slot + 4'd1 : slot;
              led_nxt  = (slot_nxt < duty_q) ? pat_q : 4'b0000;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmd_ready <= 1'b1;
      led       <= 4'b0000;
      cur_mode  <= 2'd0;
      step_cnt  <= '0;
      div_cnt   <= '0;
      slot      <= 4'd0;
      mode_q    <= 2'd0;
      pat_q     <= 4'd0;
      duty_q    <= 4'd0;
    end else begin
      cmd_ready <= ready_nxt;
      led       <= led_nxt;
      cur_mode  <= cur_mode_nxt;
      step_cnt  <= step_nxt;
      div_cnt   <= div_nxt;
      slot      <= slot_nxt;
      if (accept) begin
        mode_q <= cmd_mode;
        pat_q  <= cmd_pattern;
        duty_q <= cmd_duty;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: vector table of commands with expected
// per-2-cycle LED sequences, checked through a per-cycle scoreboard.
module tb_led_pattern_driver;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_pattern;
  logic [3:0] cmd_duty;
  logic [3:0] led;
  logic [1:0] cur_mode;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] led;
    logic [1:0] mode;
    logic       rdy;
    int         rec;
    int         t;
  } exp_t;

  typedef struct {
    logic [1:0]       mode;
    logic [3:0]       pat;
    logic [3:0]       duty;
    logic [15:0][3:0] seq;
  } vec_t;

  exp_t sb[$];
  logic [3:0] prev_led;
  logic [1:0] prev_mode;

  always #5 sys_clk = ~sys_clk;

  led_pattern_driver #(
    .STEP_CYCLES(4),
    .PWM_DIV    (2)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_pattern(cmd_pattern),
    .cmd_duty   (cmd_duty),
    .led        (led),
    .cur_mode   (cur_mode)
  );

  task automatic cyc(input logic [3:0] l, input logic [1:0] m,
                     input logic r, input int rec, input int t);
    exp_t e;
    @(posedge sys_clk);
    #1;
    e.led  = l;
    e.mode = m;
    e.rdy  = r;
    e.rec  = rec;
    e.t    = t;
    sb.push_back(e);
    prev_led  = l;
    prev_mode = m;
  endtask

  always @(negedge sys_clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if ({led, cur_mode, cmd_ready} !== {e.led, e.mode, e.rdy}) begin
        bad++;
        $display("FAIL out rec=%0d t=%0d got led=%b mode=%0d rdy=%b want led=%b mode=%0d rdy=%b",
                 e.rec, e.t, led, cur_mode, cmd_ready, e.led, e.mode, e.rdy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    vec_t v[8];
    v[0] = '{2'd0, 4'b1010, 4'd0,  64'hAAAA_AAAA_AAAA_AAAA};
    v[1] = '{2'd1, 4'b0110, 4'd9,  64'h0066_0066_0066_0066};
    v[2] = '{2'd2, 4'b0001, 4'd0,  64'h8844_2211_8844_2211};
    v[3] = '{2'd0, 4'b1111, 4'd0,  64'hFFFF_FFFF_FFFF_FFFF};
    v[4] = '{2'd2, 4'b1111, 4'd0,  64'hFFFF_FFFF_FFFF_FFFF};
    v[5] = '{2'd3, 4'b1111, 4'd4,  64'h0000_0000_0000_FFFF};
    v[6] = '{2'd3, 4'b1111, 4'd0,  64'h0000_0000_0000_0000};
    v[7] = '{2'd3, 4'b1111, 4'd15, 64'h0FFF_FFFF_FFFF_FFFF};

    sys_rst     = 1'b1;
    cmd_valid   = 1'b0;
    cmd_mode    = 2'd0;
    cmd_pattern = 4'd0;
    cmd_duty    = 4'd0;
    cyc(4'b0000, 2'd0, 1'b1, -1, 0);
    cyc(4'b0000, 2'd0, 1'b1, -1, 1);
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(4'b0000, 2'd0, 1'b1, -1, 2 + i);

    for (int r = 0; r < 8; r++) begin
      cmd_valid   = 1'b1;
      cmd_mode    = v[r].mode;
      cmd_pattern = v[r].pat;
      cmd_duty    = v[r].duty;
      cyc(prev_led, prev_mode, 1'b0, r, -1);
      cmd_mode    = ~v[r].mode;
      cmd_pattern = ~v[r].pat;
      cmd_duty    = ~v[r].duty;
      cyc(v[r].seq[0], v[r].mode, 1'b1, r, 0);
      cmd_valid = 1'b0;
      for (int t = 1; t < 48; t++)
        cyc(v[r].seq[(t / 2) % 16], v[r].mode, 1'b1, r, t);
    end

    cmd_valid   = 1'b1;
    cmd_mode    = 2'd1;
    cmd_pattern = 4'b0110;
    cmd_duty    = 4'd0;
    cyc(prev_led, prev_mode, 1'b0, 8, -1);
    cmd_valid = 1'b0;
    cyc(4'b0110, 2'd1, 1'b1, 8, 0);
    cyc(4'b0110, 2'd1, 1'b1, 8, 1);
    sys_rst     = 1'b1;
    cmd_valid   = 1'b1;
    cmd_mode    = 2'd2;
    cmd_pattern = 4'b1111;
    cyc(4'b0000, 2'd0, 1'b1, 9, 0);
    sys_rst   = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 1; i < 6; i++) cyc(4'b0000, 2'd0, 1'b1, 9, i);

    cmd_valid   = 1'b1;
    cmd_mode    = 2'd0;
    cmd_pattern = 4'b0101;
    cyc(4'b0000, 2'd0, 1'b0, 10, -1);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc(4'b0101, 2'd0, 1'b1, 10, i);

    @(negedge sys_clk);
    @(negedge sys_clk);
    if (total < 400) begin
      bad++;
      $display("FAIL too few checks total=%0d", total);
    end
    if (bad != 0) $display("FAIL bad=%0d", bad);
    else          $display("PASS");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
